window_accumulator: RTL

//   Downstream consumer of the tock() result stream: accepts 8-bit samples, sums

---
 rtl/window_accum_pkg.sv | 26 ++
 rtl/window_accumulator_if.sv | 31 +++
 rtl/sync_fifo2.sv | 52 +++++
 rtl/window_accumulator.sv | 96 +++++++++
 4 files changed

// File: rtl/window_accum_pkg.sv
// Shared types and sizing for the window accumulator.
//   DATA_WIDTH : input sample width
//   WINDOW     : samples per window (2..16)
//   SUM_WIDTH  : wide enough that WINDOW full-scale samples never wrap
//   CNT_WIDTH  : holds 0..WINDOW
//   state_t    : IDLE / ACCUM / LAST / STALL, decoded from count and flags
//   result_t   : one buffered window result {sum, samples, partial}
package window_accum_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int WINDOW     = 4;
   localparam int SUM_WIDTH  = DATA_WIDTH + $clog2(WINDOW);
   localparam int CNT_WIDTH  = $clog2(WINDOW + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      LAST,
      STALL
   } state_t;

   typedef struct packed {
      logic [SUM_WIDTH-1:0] sum;
      logic [CNT_WIDTH-1:0] samples;
      logic                 partial;
   } result_t;
endpackage

// File: rtl/window_accumulator_if.sv
// Sample-in / result-out handshake bundle for the window accumulator.
//   in_data, in_valid, in_ready : sample stream (accept on valid && ready)
//   flush                       : single-cycle request to close the open window
//   out_sum, out_samples,
//   out_partial, out_valid,
//   out_ready                   : head of the result buffer (pop on valid && ready)
// modport master : the producer/consumer side driving samples and out_ready
// modport slave  : the accumulator itself
interface window_accumulator_if;
   import window_accum_pkg::*;

   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic [SUM_WIDTH-1:0]  out_sum;
   logic [CNT_WIDTH-1:0]  out_samples;
   logic                  out_partial;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_sum, out_samples, out_partial, out_valid
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_sum, out_samples, out_partial, out_valid
   );
endinterface

// File: rtl/sync_fifo2.sv
// Two-entry FIFO of window results.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry, held stable until popped
//   full, empty     : occupancy flags, purely registered
module sync_fifo2 import window_accum_pkg::*; (
   input  logic    clock,
   input  logic    reset,
   input  logic    push,
   input  result_t push_data,
   input  logic    pop,
   output result_t head,
   output logic    full,
   output logic    empty
);
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] fill_reg;
   logic       do_push;
   logic       do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      result_t entry_reg;
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            entry_reg <= '0;
         end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
            entry_reg <= push_data;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         fill_reg   <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= !wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= !rd_ptr_reg;
         fill_reg <= fill_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
   assign full  = (fill_reg == 2'd2);
   assign empty = (fill_reg == 2'd0);
endmodule

// File: rtl/window_accumulator.sv
// Sums each window of WINDOW samples and queues the sums in a 2-entry buffer.
// A flush closes a partially filled window early (result marked partial).
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : sample input handshake, flush, result output handshake
// in_ready is decoded only from registered state, so a pop never reaches
// in_ready combinationally; space freed by a pop is seen one cycle later.
module window_accumulator (
   input logic           clock,
   input logic           reset,
   window_accumulator_if.slave bus
);
   import window_accum_pkg::*;

   localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(WINDOW);
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(WINDOW - 1);

   logic [SUM_WIDTH-1:0] acc_reg;
   logic [SUM_WIDTH-1:0] acc_next;
   logic [CNT_WIDTH-1:0] count_reg;
   logic [CNT_WIDTH-1:0] count_next;
   logic                 flush_pending_reg;
   logic                 flush_pending_next;

   logic [SUM_WIDTH-1:0] win_sum;
   logic [CNT_WIDTH-1:0] win_count;
   state_t               state;
   logic                 accept;
   logic                 close;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   result_t              push_data;
   result_t              head;

   // Window phase, decoded from the counters rather than kept as its own
   // register. STALL means a close is owed but the buffer has no room.
   always_comb begin
      state = IDLE;
      if (fifo_full && (count_reg == LAST_COUNT || flush_pending_reg)) begin
         state = STALL;
      end else if (count_reg == LAST_COUNT) begin
         state = LAST;
      end else if (count_reg != '0) begin
         state = ACCUM;
      end
   end

   always_comb begin
      accept    = bus.in_valid && (state != STALL);
      // Sum and count including this cycle's sample, so a flush or the
      // final sample closes the window with that sample folded in.
      win_sum   = acc_reg + (accept ? SUM_WIDTH'(bus.in_data) : '0);
      win_count = count_reg + (accept ? CNT_WIDTH'(1) : '0);
      close     = (win_count == FULL_COUNT) ||
                  ((bus.flush || flush_pending_reg) && (win_count != '0));
      push      = close && !fifo_full;
      push_data = '{sum: win_sum, samples: win_count, partial: (win_count != FULL_COUNT)};
      acc_next  = push ? '0 : win_sum;
      count_next = push ? '0 : win_count;
      // A full window cannot be owed while full (in_ready blocks its last
      // sample), so an unserved close here is always a flush.
      flush_pending_next = close && fifo_full;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_reg           <= '0;
         count_reg         <= '0;
         flush_pending_reg <= 1'b0;
      end else begin
         acc_reg           <= acc_next;
         count_reg         <= count_next;
         flush_pending_reg <= flush_pending_next;
      end
   end

   assign pop = !fifo_empty && bus.out_ready;

   sync_fifo2 u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.in_ready    = (state != STALL);
   assign bus.out_valid   = !fifo_empty;
   assign bus.out_sum     = head.sum;
   assign bus.out_samples = head.samples;
   assign bus.out_partial = head.partial;
endmodule
